regfile_access_ctrl: RTL and testbench
======================================

// Module: regfile_access_ctrl
// PURPOSE
//  Initiator side of the 16x16 dual-port register file. Arbitrates operand reads
//  against writebacks on the file's shared read/write address port (rwa1).
//  Buffers writebacks and forwards buffered data to reads.
//  Sits between decode/execute and the register file.
// PARAMETERS
//  DATA_W     16  register width
//  ADDR_W     4   register index width
//  WB_DEPTH   2   writeback buffer entries (>=1)
//  STARVE_MAX 2   consecutive write-granted cycles while a read waits before read wins
// PORTS
//  clk         in  1       clock, all state on rising edge
//  rst         in  1       asynchronous, active-low reset
//  rd_req_valid in 1       operand read request
//  rd_req_ready out 1      request accepted when valid&ready
//  rd_src1     in  ADDR_W  first operand index (driven onto rf_rwa1)
//  rd_src2     in  ADDR_W  second operand index (driven onto rf_ra2)
//  op_valid    out 1       operand response valid
//  op_ready    in  1       consumer takes response when valid&ready
//  op_a, op_b  out DATA_W  operand values for src1/src2
//  wb_valid    in  1       writeback request
//  wb_ready    out 1       writeback accepted when valid&ready
//  wb_addr     in  ADDR_W  destination index
//  wb_data     in  DATA_W  destination value
//  rf_rwa1     out ADDR_W  file read1/write address
//  rf_ra2      out ADDR_W  file read2 address
//  rf_rd1, rf_rd2 in DATA_W file combinational read data
//  rf_we       out 1       file write enable
//  rf_wd       out DATA_W  file write data
// BEHAVIOUR
//  Reset (rst=0, async): buffer empty, starve count 0, op_valid=0, op_a=op_b=0,
//   rf_we=0, rf_rwa1=rf_ra2=0, rf_wd=0; wb_ready=1 and rd_req_ready=1 once released.
//   A reset mid-operation discards buffered writes and any held response.
//  Per cycle, exactly one port-1 user: WRITE (buffer head -> file) or READ.
//  Grant: WRITE if buffer non-empty, unless a read can issue and starve==STARVE_MAX.
//   Then READ.
//   starve increments on WRITE grant while a read could issue. It clears on READ grant.
//  Read can issue when rd_req_valid and (no response held or op_ready this cycle).
//   rd_req_ready = READ granted.
//  READ cycle: rf_rwa1=rd_src1, rf_ra2=rd_src2, rf_we=0. At the edge:
//   op_a <= src1 value, op_b <= src2 value, op_valid <= 1.
//   Latency is 1 cycle from acceptance.
//   Value = youngest buffer entry with matching addr, else rf_rd1/rf_rd2.
//   A writeback accepted in the same cycle is younger: the read sees the old value.
//  WRITE cycle: rf_rwa1=head.addr, rf_wd=head.data, rf_we=1. The head pops at the edge.
//   rf_ra2 holds its last value.
//  Idle (no grant): rf_we=0.
//  Response hold: op_valid stays 1 and op_a/op_b stay stable until op_ready.
//   valid&ready with no new READ clears op_valid.
//  wb_ready = count<WB_DEPTH, from registered count. A pop does not free a slot
//   in the same cycle. Same-cycle push+pop keeps count unchanged and preserves order.
//  Full buffer: wb_ready=0. Reads still issue under starvation rule.
//  Empty buffer: every issuable read is granted immediately.
//  Two buffered entries for the same addr: commit in order; forwarding uses the younger.
//  Combinational rd_req_* -> rf_* paths are permitted. No wb_* -> rf_* path is permitted.
// STRUCTURE
//  regfile_pkg: DATA_W/ADDR_W defaults and the grant encoding localparams (G_IDLE/G_READ/G_WRITE).
//  Sub-module regfile_wb_buffer: WB_DEPTH FIFO with count, head outputs and two
//   parallel youngest-match forward lookups (hit + data per lookup).
//  Top: grant logic, starve counter, response registers.
// TESTING
//  Write idle: wb r3=0x1234, no reads.
//   Expect rf_we=1, rf_rwa1=3, rf_wd=0x1234 exactly 1 cycle after acceptance.
//  Read idle: file r5=0xAAAA, r6=0x5555; read(5,6).
//   Expect op_valid next cycle, op_a=0xAAAA, op_b=0x5555, rf_we=0 during the read.
//  Forwarding: wb r7=0xBEEF, then read(7,7) the next cycle while the entry is still
//   buffered. Expect op_a=op_b=0xBEEF. wb r7=1 then r7=2 buffered: read gives 2.
//  Same-cycle order: r4=0x0001 in file; wb r4=0x0002 and read(4,0) accepted together.
//   Expect op_a=0x0001; a later read returns 0x0002.
//  Starvation/full: hold wb_valid with 3 entries while a read waits.
//   Expect the read granted after 2 write cycles, wb_ready=0 while count=2,
//   and all 3 writes committed in order.
//  Backpressure/reset: op_ready=0 with response held.
//   Expect rd_req_ready=0 and stable op_a. Assert rst mid-buffer.
//   Expect op_valid=0, rf_we=0 immediately and no further file writes.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and grant encoding for the register-file access controller.
package regfile_pkg;

    localparam int unsigned DEFAULT_DATA_W = 16;
    localparam int unsigned DEFAULT_ADDR_W = 4;

    typedef logic [1:0] grant_t;

    localparam grant_t G_IDLE  = 2'd0;
    localparam grant_t G_READ  = 2'd1;
    localparam grant_t G_WRITE = 2'd2;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Handshake and register-file bus bundle between decode/execute, the controller and the file.
interface regfile_access_ctrl_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
);
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_src1;
    logic [ADDR_W-1:0] rd_src2;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] rf_rwa1;
    logic [ADDR_W-1:0] rf_ra2;
    logic [DATA_W-1:0] rf_rd1;
    logic [DATA_W-1:0] rf_rd2;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wd;

    // Controller side.
    modport slave (
        input  rd_req_valid, rd_src1, rd_src2, op_ready, wb_valid, wb_addr, wb_data,
               rf_rd1, rf_rd2,
        output rd_req_ready, op_valid, op_a, op_b, wb_ready, rf_rwa1, rf_ra2, rf_we, rf_wd
    );

    // Pipeline and register-file side.
    modport master (
        output rd_req_valid, rd_src1, rd_src2, op_ready, wb_valid, wb_addr, wb_data,
               rf_rd1, rf_rd2,
        input  rd_req_ready, op_valid, op_a, op_b, wb_ready, rf_rwa1, rf_ra2, rf_we, rf_wd
    );

endinterface

// File: rtl/regfile_wb_buffer.sv
// Writeback FIFO (shift style, entry 0 is the head) with two youngest-match forward lookups.
module regfile_wb_buffer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    input  logic [ADDR_W-1:0] lk1_addr,
    output logic              lk1_hit,
    output logic [DATA_W-1:0] lk1_data,
    input  logic [ADDR_W-1:0] lk2_addr,
    output logic              lk2_hit,
    output logic [DATA_W-1:0] lk2_data
);
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d, wr_idx;

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
        wr_idx  = count_q;
        if (pop) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                addr_d[i] = addr_q[i+1];
                data_d[i] = data_q[i+1];
            end
            count_d = count_q - CNT_W'(1);
            wr_idx  = count_q - CNT_W'(1);
        end
        // Push lands behind whatever survives the pop, so order is preserved.
        if (push) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (CNT_W'(i) == wr_idx) begin
                    addr_d[i] = push_addr;
                    data_d[i] = push_data;
                end
            end
            count_d = count_d + CNT_W'(1);
        end
    end

    // Later (younger) matches override earlier ones.
    always_comb begin
        lk1_hit  = 1'b0;
        lk1_data = '0;
        lk2_hit  = 1'b0;
        lk2_data = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (CNT_W'(i) < count_q) begin
                if (addr_q[i] == lk1_addr) begin
                    lk1_hit  = 1'b1;
                    lk1_data = data_q[i];
                end
                if (addr_q[i] == lk2_addr) begin
                    lk2_hit  = 1'b1;
                    lk2_data = data_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign count     = count_q;
    assign head_addr = addr_q[0];
    assign head_data = data_q[0];

endmodule

// File: rtl/regfile_access_ctrl.sv
// Arbitrates operand reads against buffered writebacks on the shared rwa1 file port.
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W     = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
    parameter int unsigned WB_DEPTH   = 2,
    parameter int unsigned STARVE_MAX = 2
) (
    input logic                 clk,
    input logic                 rst,
    regfile_access_ctrl_if.slave bus
);
    localparam int unsigned CNT_W    = $clog2(WB_DEPTH + 1);
    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 2);

    logic [CNT_W-1:0]    count;
    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_data;
    logic                hit1, hit2;
    logic [DATA_W-1:0]   fwd1, fwd2;
    logic                push, pop, has_wr, resp_free, read_wins, can_read;
    grant_t              grant;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                op_valid_q, op_valid_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic [ADDR_W-1:0]   ra2_q, ra2_d;

    regfile_wb_buffer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (WB_DEPTH)
    ) u_wb_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_addr (bus.wb_addr),
        .push_data (bus.wb_data),
        .pop       (pop),
        .count     (count),
        .head_addr (head_addr),
        .head_data (head_data),
        .lk1_addr  (bus.rd_src1),
        .lk1_hit   (hit1),
        .lk1_data  (fwd1),
        .lk2_addr  (bus.rd_src2),
        .lk2_hit   (hit2),
        .lk2_data  (fwd2)
    );

    // wb_ready comes from the registered count only, keeping wb_* off the rf_* paths.
    assign bus.wb_ready = count < CNT_W'(WB_DEPTH);
    assign push         = bus.wb_valid && bus.wb_ready;
    assign has_wr       = count != '0;
    assign resp_free    = !op_valid_q || bus.op_ready;
    assign read_wins    = starve_q == STARVE_W'(STARVE_MAX);
    assign can_read     = bus.rd_req_valid && resp_free;
    // Equals the READ grant whenever a request is present.
    assign bus.rd_req_ready = resp_free && (!has_wr || read_wins);
    assign pop          = grant == G_WRITE;

    always_comb begin
        grant = G_IDLE;
        if (has_wr && !(can_read && read_wins)) begin
            grant = G_WRITE;
        end else if (can_read) begin
            grant = G_READ;
        end
    end

    always_comb begin
        starve_d    = starve_q;
        op_valid_d  = op_valid_q && !bus.op_ready;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        ra2_d       = ra2_q;
        bus.rf_we   = 1'b0;
        bus.rf_rwa1 = '0;
        bus.rf_wd   = '0;
        case (grant)
            G_READ: begin
                bus.rf_rwa1 = bus.rd_src1;
                ra2_d       = bus.rd_src2;
                op_valid_d  = 1'b1;
                op_a_d      = hit1 ? fwd1 : bus.rf_rd1;
                op_b_d      = hit2 ? fwd2 : bus.rf_rd2;
                starve_d    = '0;
            end
            G_WRITE: begin
                bus.rf_we   = 1'b1;
                bus.rf_rwa1 = head_addr;
                bus.rf_wd   = head_data;
                if (can_read) starve_d = starve_q + STARVE_W'(1);
            end
            default: ;
        endcase
        bus.rf_ra2 = ra2_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q   <= '0;
            op_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            ra2_q      <= '0;
        end else begin
            starve_q   <= starve_d;
            op_valid_q <= op_valid_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            ra2_q      <= ra2_d;
        end
    end

    assign bus.op_valid = op_valid_q;
    assign bus.op_a     = op_a_q;
    assign bus.op_b     = op_b_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: file model, directed steps, scoreboards for responses and commits.
module tb_regfile_access_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_access_ctrl_if #(.DATA_W(16), .ADDR_W(4)) bus ();

    regfile_access_ctrl #(
        .DATA_W     (16),
        .ADDR_W     (4),
        .WB_DEPTH   (2),
        .STARVE_MAX (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register-file model: combinational reads, write on the rising edge.
    logic [15:0] mem [16] = '{4: 16'h0001, 5: 16'hAAAA, 6: 16'h5555, default: 16'h0000};
    // Architectural view: file plus every accepted writeback.
    logic [15:0] shadow [16] = '{4: 16'h0001, 5: 16'hAAAA, 6: 16'h5555, default: 16'h0000};
    logic [31:0] op_q [$];
    logic [31:0] wr_q [$];

    assign bus.rf_rd1 = mem[bus.rf_rwa1];
    assign bus.rf_rd2 = mem[bus.rf_ra2];

    always @(posedge clk) begin
        if (bus.rf_we) mem[bus.rf_rwa1] <= bus.rf_wd;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Mid-cycle monitor: handshakes seen here take effect at the next rising edge.
    always @(negedge clk) begin
        logic [31:0] exp;
        if (!rst) begin
            op_q.delete();
            wr_q.delete();
            shadow = mem;
        end else begin
            if (bus.op_valid && bus.op_ready) begin
                check("resp_pending", 32'(op_q.size() > 0), 32'd1);
                if (op_q.size() > 0) begin
                    exp = op_q.pop_front();
                    check("resp_operands", {bus.op_a, bus.op_b}, exp);
                end
            end
            if (bus.rf_we) begin
                check("commit_pending", 32'(wr_q.size() > 0), 32'd1);
                if (wr_q.size() > 0) begin
                    exp = wr_q.pop_front();
                    check("commit_order", {12'h0, bus.rf_rwa1, bus.rf_wd}, exp);
                end
            end
            // Reads see the state before a same-cycle writeback.
            if (bus.rd_req_valid && bus.rd_req_ready)
                op_q.push_back({shadow[bus.rd_src1], shadow[bus.rd_src2]});
            if (bus.wb_valid && bus.wb_ready) begin
                wr_q.push_back({12'h0, bus.wb_addr, bus.wb_data});
                shadow[bus.wb_addr] = bus.wb_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic v, input logic [3:0] s1, input logic [3:0] s2);
        bus.rd_req_valid = v;
        bus.rd_src1      = s1;
        bus.rd_src2      = s2;
    endtask

    task automatic set_wb(input logic v, input logic [3:0] a, input logic [15:0] d);
        bus.wb_valid = v;
        bus.wb_addr  = a;
        bus.wb_data  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.op_ready = 1'b1;
        set_rd(1'b0, 4'd0, 4'd0);
        set_wb(1'b0, 4'd0, 16'h0);
        #1 rst = 1'b0;
        #1;
        check("rst_op_valid", 32'(bus.op_valid), 32'd0);
        check("rst_op_ab", {bus.op_a, bus.op_b}, 32'h0);
        check("rst_rf_we", 32'(bus.rf_we), 32'd0);
        check("rst_rf_addr", {bus.rf_rwa1, bus.rf_ra2}, 32'h0);
        check("rst_rf_wd", 32'(bus.rf_wd), 32'h0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rel_wb_ready", 32'(bus.wb_ready), 32'd1);
        check("rel_rd_ready", 32'(bus.rd_req_ready), 32'd1);

        // Write while idle: commit appears exactly one cycle after acceptance.
        set_wb(1'b1, 4'd3, 16'h1234);
        #1 check("wi_we_accept_cycle", 32'(bus.rf_we), 32'd0);
        tick();
        set_wb(1'b0, 4'd0, 16'h0);
        #1;
        check("wi_we", 32'(bus.rf_we), 32'd1);
        check("wi_addr_data", {bus.rf_rwa1, bus.rf_wd}, {4'd3, 16'h1234});
        tick();
        #1 check("wi_we_after", 32'(bus.rf_we), 32'd0);

        // Read while idle.
        set_rd(1'b1, 4'd5, 4'd6);
        #1;
        check("ri_ready", 32'(bus.rd_req_ready), 32'd1);
        check("ri_we", 32'(bus.rf_we), 32'd0);
        check("ri_addrs", {bus.rf_rwa1, bus.rf_ra2}, {4'd5, 4'd6});
        tick();
        set_rd(1'b0, 4'd0, 4'd0);
        #1;
        check("ri_valid", 32'(bus.op_valid), 32'd1);
        check("ri_ops", {bus.op_a, bus.op_b}, 32'hAAAA5555);
        tick();
        #1 check("ri_valid_clear", 32'(bus.op_valid), 32'd0);

        // Same-cycle read and writeback: read sees the older value.
        set_rd(1'b1, 4'd4, 4'd0);
        set_wb(1'b1, 4'd4, 16'h0002);
        #1 check("sc_ready", 32'(bus.rd_req_ready), 32'd1);
        tick();
        set_wb(1'b0, 4'd0, 16'h0);
        #1;
        check("sc_old_value", 32'(bus.op_a), 32'h0001);
        check("sc_write_wins", {31'h0, bus.rf_we}, {31'h0, 1'b1});
        check("sc_read_waits", 32'(bus.rd_req_ready), 32'd0);
        tick();
        #1 check("sc_read_empty_buf", 32'(bus.rd_req_ready), 32'd1);
        tick();
        set_rd(1'b0, 4'd0, 4'd0);
        #1 check("sc_new_value", 32'(bus.op_a), 32'h0002);
        tick();

        // Starvation, full buffer, forwarding.
        set_wb(1'b1, 4'd10, 16'h000A);
        set_rd(1'b1, 4'd0, 4'd1);
        #1 check("st_c0_ready", 32'(bus.rd_req_ready), 32'd1);
        tick();
        set_wb(1'b1, 4'd11, 16'h000B);
        set_rd(1'b1, 4'd10, 4'd11);
        #1;
        check("st_c1_ready", 32'(bus.rd_req_ready), 32'd0);
        check("st_c1_write", {bus.rf_we, bus.rf_rwa1}, {1'b1, 4'd10});
        check("st_c1_ra2_hold", 32'(bus.rf_ra2), 32'd1);
        tick();
        set_wb(1'b1, 4'd10, 16'h00AA);
        #1;
        check("st_c2_ready", 32'(bus.rd_req_ready), 32'd0);
        check("st_c2_write", {bus.rf_we, bus.rf_rwa1}, {1'b1, 4'd11});
        tick();
        set_wb(1'b1, 4'd10, 16'h0BAD);
        #1;
        check("st_c3_read_wins", 32'(bus.rd_req_ready), 32'd1);
        check("st_c3_we", 32'(bus.rf_we), 32'd0);
        tick();
        set_wb(1'b1, 4'd13, 16'hDDDD);
        set_rd(1'b1, 4'd10, 4'd13);
        #1;
        check("st_full", 32'(bus.wb_ready), 32'd0);
        check("st_fwd_ops", {bus.op_a, bus.op_b}, 32'h00AA000B);
        check("st_c4_ready", 32'(bus.rd_req_ready), 32'd0);
        tick();
        #1;
        check("st_c5_wb_ready", 32'(bus.wb_ready), 32'd1);
        check("st_c5_wd", 32'(bus.rf_wd), 32'h0BAD);
        tick();
        set_wb(1'b0, 4'd0, 16'h0);
        #1 check("st_c6_read_wins", 32'(bus.rd_req_ready), 32'd1);
        tick();
        set_rd(1'b0, 4'd0, 4'd0);
        #1;
        check("st_c7_ops", {bus.op_a, bus.op_b}, 32'h0BADDDDD);
        check("st_c7_write", {bus.rf_we, bus.rf_rwa1}, {1'b1, 4'd13});
        tick();
        tick();

        // Backpressure, then reset with a write buffered.
        bus.op_ready = 1'b0;
        set_rd(1'b1, 4'd5, 4'd6);
        #1 check("bp_ready", 32'(bus.rd_req_ready), 32'd1);
        tick();
        set_rd(1'b1, 4'd3, 4'd3);
        set_wb(1'b1, 4'd1, 16'h1111);
        #1;
        check("bp_held_valid", 32'(bus.op_valid), 32'd1);
        check("bp_rd_blocked", 32'(bus.rd_req_ready), 32'd0);
        check("bp_op_a", 32'(bus.op_a), 32'hAAAA);
        tick();
        set_wb(1'b1, 4'd2, 16'h2222);
        #1;
        check("bp_op_a_stable", 32'(bus.op_a), 32'hAAAA);
        check("bp_rd_still_blocked", 32'(bus.rd_req_ready), 32'd0);
        tick();
        set_wb(1'b0, 4'd0, 16'h0);
        set_rd(1'b0, 4'd0, 4'd0);
        #1 check("bp_pending_write", {bus.rf_we, bus.rf_rwa1}, {1'b1, 4'd2});
        rst = 1'b0;
        #1;
        check("rs_we", 32'(bus.rf_we), 32'd0);
        check("rs_op_valid", 32'(bus.op_valid), 32'd0);
        check("rs_op_a", 32'(bus.op_a), 32'h0);
        tick();
        tick();
        rst = 1'b1;
        bus.op_ready = 1'b1;
        tick();
        tick();
        tick();
        check("rs_r2_not_written", 32'(mem[2]), 32'h0000);
        set_rd(1'b1, 4'd2, 4'd1);
        #1 check("rs_read_ready", 32'(bus.rd_req_ready), 32'd1);
        tick();
        set_rd(1'b0, 4'd0, 4'd0);
        #1 check("rs_read_ops", {bus.op_a, bus.op_b}, 32'h00001111);
        tick();
        tick();
        check("end_resp_queue", 32'(op_q.size()), 32'd0);
        check("end_commit_queue", 32'(wr_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
